mac_arbiter: RTL and testbench
==============================

Name: mac_arbiter

Overview:
- Round-robin scheduler that shares one sequential multiply-accumulate unit among N_REQ requesters.
- Captures the winning requester's operands, clears and starts the MAC, and waits for mac_busy to drop.
- Returns the product and a done pulse to that requester; flags a timeout if the MAC hangs.
- Sits between the reservoir/readout compute clients and the single MAC instance.

Parameters:
- DATA_WIDTH, 32, operand/result width
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, max cycles spent in WAIT before declaring error

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  N_REQ  per-requester level request
- req_a  input  N_REQ*DATA_WIDTH  packed multiplicand, slice i = requester i
- req_b  input  N_REQ*DATA_WIDTH  packed multiplier, slice i = requester i
- gnt  output  N_REQ  one-hot grant, held for the whole operation
- done  output  N_REQ  one-cycle completion pulse to the granted requester
- result  output  DATA_WIDTH  product of last completed op
- err  output  1  one-cycle pulse coincident with done on timeout
- mac_clr  output  1  one-cycle accumulator clear to MAC
- mac_start  output  1  one-cycle start to MAC
- mac_a  output  DATA_WIDTH  latched operand a
- mac_b  output  DATA_WIDTH  latched operand b
- mac_busy  input  1  MAC busy
- mac_dout  input  DATA_WIDTH  MAC accumulator value

Behaviour:
- Reset (rst=0, async): state IDLE; gnt, done, err, mac_clr, mac_start = 0; result, mac_a, mac_b, timeout counter = 0; RR pointer = 0 (requester 0 highest priority).
- All outputs registered.
- FSM states and transitions:
  - IDLE: if req != 0, select winner = first set bit searching upward from pointer, wrapping. Register gnt[winner]=1, latch mac_a/mac_b from winner's slices, go to CLEAR. Else stay.
  - CLEAR: mac_clr=1 for this cycle; go to START.
  - START: mac_start=1 for this cycle; go to SETTLE.
  - SETTLE: one cycle, mac_busy ignored (MAC registers start); clear timeout counter; go to WAIT.
  - WAIT: if mac_busy=0, result<=mac_dout, go to DONE. Else increment counter; when counter reaches TIMEOUT-1 with busy still 1, result<=0, flag error, go to DONE.
  - DONE: done[winner]=1 and err=flag for this cycle; pointer <= winner+1 mod N_REQ; gnt cleared on exit; go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> gnt at 1 -> mac_clr 1 -> mac_start 2 -> SETTLE 3 -> WAIT from 4. done pulses at cycle 5 at the earliest (busy already low at 4), else 1 cycle after busy falls.
- Back-to-back: minimum 6 cycles per op; IDLE always lasts at least one cycle.
- req handling:
  - Level-sensitive, sampled only in IDLE; changes while granted are ignored.
  - Operands sampled only at grant.
  - A requester still asserting req after done is re-arbitrated at lowest priority.
- b=0: MAC never asserts busy; WAIT sees busy=0 and done fires with result=mac_dout (0 after clear).
- result holds until the next DONE.
- gnt never has more than one bit set; done only on the granted bit.
- Reset mid-operation: immediate abort to reset values; no done issued; MAC is cleared by the next op's mac_clr.
- Pointer wraps N_REQ-1 -> 0.

Test Plan:
- Single op: req=0001, a0=7, b0=6, MAC busy 6 cycles -> gnt=0001; mac_clr then mac_start one cycle each; done=0001; result=42; err=0.
- Simultaneous: req=0101 held, a0=3 b0=4, a2=5 b2=5 -> first done[0] result=12, then done[2] result=25; then req0 granted again (RR order 0,2,0,2).
- Fairness: req=1111 continuous -> grant order 0,1,2,3,0; no requester granted twice before all served; ops spaced at most 6 + MAC cycles.
- b=0: req=0010, a1=9, b1=0, busy never rises -> done[1] at cycle 5; result=0.
- Timeout: TIMEOUT=16, mac_busy stuck 1 -> done and err pulse together 16 cycles after WAIT entry; result=0; next request still served.
- Reset mid-op: rst=0 during WAIT -> gnt/done/mac_* to 0 immediately, no done; after release req=1000 granted first attempt, pointer back at 0.

Source files
------------

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin scheduler sharing one sequential MAC among N_REQ requesters
module mac_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       result,
    output logic                        err,
    output logic                        mac_clr,
    output logic                        mac_start,
    output logic [DATA_WIDTH-1:0]       mac_a,
    output logic [DATA_WIDTH-1:0]       mac_b,
    input  logic                        mac_busy,
    input  logic [DATA_WIDTH-1:0]       mac_dout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0] NR = (IW + 1)'(N_REQ);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_SETTLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [N_REQ-1:0]      r_gnt;
    logic [N_REQ-1:0]      r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_err;
    logic                  r_clr;
    logic                  r_start;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    logic [N_REQ-1:0]      w_rot;
    logic [IW-1:0]         w_off;
    logic [IW:0]           w_sum;
    logic [IW-1:0]         w_win;
    logic [IW-1:0]         w_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_timeout;
    logic                  w_finish;

    // Requests rotated so bit 0 is the requester currently holding top priority
    assign w_rot     = N_REQ'({req, req} >> r_ptr);
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win     = (w_sum >= NR) ? IW'(w_sum - NR) : IW'(w_sum);
    assign w_ptr_nxt = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_finish  = (r_state == S_WAIT) && (!mac_busy || w_timeout);

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;
    assign mac_clr   = r_clr;
    assign mac_start = r_start;
    assign mac_a     = r_a;
    assign mac_b     = r_b;

    // Offset of the first pending request above the pointer (lowest offset wins)
    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) if (w_rot[k]) w_off = IW'(k);
    end

    // Operand slices belonging to the arbitration winner
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win == IW'(k)) begin
                w_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_b = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state sequencing of one MAC operation
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (|req) ? S_CLEAR : S_IDLE;
            S_CLEAR:  w_next = S_START;
            S_START:  w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT:   w_next = w_finish ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Registered outputs, grant bookkeeping, timeout counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_clr    <= 1'b0;
            r_start  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_clr   <= (r_state == S_IDLE) && (|req);
            r_start <= (r_state == S_CLEAR);
            r_done  <= w_finish ? r_gnt : '0;
            r_err   <= w_finish && mac_busy;
            if ((r_state == S_IDLE) && (|req)) begin
                r_gnt <= N_REQ'(1) << w_win;
                r_idx <= w_win;
                r_a   <= w_a;
                r_b   <= w_b;
            end
            if (r_state == S_DONE) begin
                r_gnt <= '0;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == S_SETTLE) r_cnt <= '0;
            else if ((r_state == S_WAIT) && mac_busy && !w_timeout) r_cnt <= r_cnt + 1'b1;
            if (w_finish) r_result <= mac_busy ? '0 : mac_dout;
        end
    end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: randomized directed bench for mac_arbiter with a behavioural MAC and RR reference model
module tb_mac_arbiter;
    localparam int DW = 32;
    localparam int NQ = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NQ-1:0]   req = '0;
    logic [NQ*DW-1:0] req_a = '0;
    logic [NQ*DW-1:0] req_b = '0;
    logic [NQ-1:0]   gnt;
    logic [NQ-1:0]   done;
    logic [DW-1:0]   result;
    logic            err;
    logic            mac_clr;
    logic            mac_start;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic            mac_busy;
    logic [DW-1:0]   mac_dout;

    logic [DW-1:0]   m_acc = '0;
    logic            m_busy;
    int              m_cnt;
    int              busy_len = 1;
    bit              stuck = 1'b0;

    int              n_tests = 0;
    int              n_fail = 0;
    int              m_ptr = 0;
    logic [DW-1:0]   prev_res = '0;
    logic [DW-1:0]   a_in [NQ];
    logic [DW-1:0]   b_in [NQ];

    mac_arbiter #(.DATA_WIDTH(DW), .N_REQ(NQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .mac_clr(mac_clr), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_busy(mac_busy), .mac_dout(mac_dout)
    );

    always #5 clk = ~clk;

    assign mac_busy = m_busy;
    assign mac_dout = m_acc;

    // Behavioural sequential MAC: busy for busy_len cycles after start (never for b=0)
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (mac_start) begin
                m_busy <= (mac_b != 0);
                m_cnt  <= busy_len;
            end else if (m_busy && !stuck) begin
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    m_acc  <= m_acc + mac_a * mac_b;
                end else m_cnt <= m_cnt - 1;
            end
            if (mac_clr) m_acc <= '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NQ-1:0] r, input int p);
        for (int k = 0; k < NQ; k++) if (r[(p + k) % NQ]) return (p + k) % NQ;
        return 0;
    endfunction

    task automatic do_op(input logic [NQ-1:0] r, input int len, input bit stk);
        int w;
        int lat;
        int cyc;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [DW-1:0] er;
        logic [NQ-1:0] oh;
        w   = rr_pick(r, m_ptr);
        ea  = a_in[w];
        eb  = b_in[w];
        er  = stk ? '0 : ea * eb;
        lat = stk ? 4 + TO : ((eb == 0) ? 5 : 4 + len);
        oh  = NQ'(1 << w);
        for (int k = 0; k < NQ; k++) begin
            req_a[k*DW +: DW] = a_in[k];
            req_b[k*DW +: DW] = b_in[k];
        end
        req = r;
        busy_len = len;
        stuck = stk;
        @(posedge clk); #1;
        chk("gnt", gnt, oh);
        chk("clr_pulse", mac_clr, 1);
        chk("start_early", mac_start, 0);
        chk("mac_a", mac_a, ea);
        chk("mac_b", mac_b, eb);
        chk("result_hold", result, prev_res);
        req = NQ'($urandom);
        req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
        cyc = 2;
        chk("clr_end", mac_clr, 0);
        chk("start_pulse", mac_start, 1);
        chk("gnt_held", gnt, oh);
        while (done === '0 && cyc < lat + 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("done", done, oh);
        chk("err", err, stk);
        chk("result", result, er);
        chk("gnt_at_done", gnt, oh);
        chk("mac_a_held", mac_a, ea);
        m_ptr = (w + 1) % NQ;
        prev_res = er;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("err_pulse", err, 0);
        chk("gnt_release", gnt, 0);
        chk("result_keep", result, er);
    endtask

    initial begin
        for (int k = 0; k < NQ; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_clr", mac_clr, 0);
        chk("rst_start", mac_start, 0);
        chk("rst_result", result, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_gnt", gnt, 0);
            chk("idle_clr", mac_clr, 0);
        end

        a_in[0] = 7; b_in[0] = 6;
        do_op(4'b0001, 6, 0);

        a_in[0] = 3; b_in[0] = 4; a_in[2] = 5; b_in[2] = 5;
        repeat (4) do_op(4'b0101, $urandom_range(1, 5), 0);

        repeat (5) begin
            for (int k = 0; k < NQ; k++) begin
                a_in[k] = $urandom;
                b_in[k] = $urandom;
            end
            do_op(4'b1111, $urandom_range(1, 6), 0);
        end

        a_in[1] = 9; b_in[1] = 0;
        do_op(4'b0010, 3, 0);

        a_in[0] = 21; b_in[0] = 2;
        do_op(4'b0001, 1, 1);
        a_in[3] = 100; b_in[3] = 3;
        do_op(4'b1001, 2, 0);

        repeat (20) begin
            for (int k = 0; k < NQ; k++) begin
                a_in[k] = $urandom;
                b_in[k] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            end
            do_op(NQ'($urandom_range(1, 15)), $urandom_range(1, 8), 0);
        end

        a_in[1] = 4; b_in[1] = 4;
        do_op(4'b0010, 2, 0);
        a_in[2] = 11; b_in[2] = 13;
        for (int k = 0; k < NQ; k++) begin
            req_a[k*DW +: DW] = a_in[k];
            req_b[k*DW +: DW] = b_in[k];
        end
        req = 4'b0100;
        stuck = 1'b1;
        busy_len = 1;
        @(posedge clk); #1;
        chk("abort_gnt", gnt, 4'b0100);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_gnt_clr", gnt, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_clr", mac_clr, 0);
        chk("abort_start", mac_start, 0);
        chk("abort_mac_a", mac_a, 0);
        chk("abort_mac_b", mac_b, 0);
        chk("abort_result", result, 0);
        stuck = 1'b0;
        req = '0;
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        rst = 1'b1;
        m_ptr = 0;
        prev_res = '0;
        a_in[0] = 8; b_in[0] = 8; a_in[3] = 6; b_in[3] = 7;
        do_op(4'b1001, 3, 0);
        do_op(4'b1000, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
